// File: rtl/input_conditioner.sv
// input_conditioner
// Synchronises and debounces the board pushbuttons and slide switches for the
// game core, and generates press/change pulses plus auto-repeat pulses for
// the paddle buttons.
//
// Ports:
//   CLK_40M     in   system clock (single domain)
//   RESET       in   synchronous, active-high reset
//   BTN_RAW     in   [3:0] raw buttons {B, A, RIGHT, LEFT}
//   SW_RAW      in   [2:0] raw switches {IGNORE_DEATH, PAUSE, RESET}
//   BTN_LEVEL   out  [3:0] debounced button levels
//   BTN_PRESS   out  [3:0] one-cycle pulse on each debounced rising edge
//   BTN_REPEAT  out  [1:0] {RIGHT, LEFT} press pulse plus auto-repeat pulses
//   SW_LEVEL    out  [2:0] debounced switch levels
//   SW_CHANGE   out  [2:0] one-cycle pulse on either debounced edge
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 400000,
    parameter int unsigned REPEAT_DELAY    = 16000000,
    parameter int unsigned REPEAT_PERIOD   = 4000000
) (
    input  logic       CLK_40M,
    input  logic       RESET,
    input  logic [3:0] BTN_RAW,
    input  logic [2:0] SW_RAW,
    output logic [3:0] BTN_LEVEL,
    output logic [3:0] BTN_PRESS,
    output logic [1:0] BTN_REPEAT,
    output logic [2:0] SW_LEVEL,
    output logic [2:0] SW_CHANGE
);

    localparam int unsigned NCH  = 7;
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W = $clog2(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
    localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    // Channel order: bits 3:0 buttons, bits 6:4 switches.
    logic [NCH-1:0]  s1;
    logic [NCH-1:0]  s2;
    logic [NCH-1:0]  stable;
    logic [DB_W-1:0] db_cnt [NCH];

    logic [NCH-1:0]  rise;
    logic [NCH-1:0]  fall;

    logic [3:0]      press_q;
    logic [2:0]      change_q;

    rpt_state_t      rpt_state [2];
    logic [RP_W-1:0] rpt_cnt   [2];
    logic [1:0]      rpt_pulse;

    // Rise/fall flag the edge at which `stable` is about to flip, so every
    // pulse register updates on the same edge as the level.
    always_comb begin
        rise = '0;
        fall = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if ((s2[i] != stable[i]) && (db_cnt[i] == DB_LAST)) begin
                rise[i] = s2[i];
                fall[i] = ~s2[i];
            end
        end
    end

    always_ff @(posedge CLK_40M) begin
        if (RESET) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            press_q  <= '0;
            change_q <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1 <= {SW_RAW, BTN_RAW};
            s2 <= s1;
            for (int unsigned i = 0; i < NCH; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
            press_q  <= rise[3:0];
            change_q <= rise[6:4] | fall[6:4];
        end
    end

    // Auto-repeat for LEFT (0) and RIGHT (1). A falling level wins over a
    // repeat pulse due on the same edge.
    always_ff @(posedge CLK_40M) begin
        if (RESET) begin
            rpt_pulse <= '0;
            for (int unsigned j = 0; j < 2; j++) begin
                rpt_state[j] <= RPT_IDLE;
                rpt_cnt[j]   <= '0;
            end
        end else begin
            rpt_pulse <= '0;
            for (int unsigned j = 0; j < 2; j++) begin
                if (fall[j]) begin
                    rpt_state[j] <= RPT_IDLE;
                    rpt_cnt[j]   <= '0;
                end else begin
                    case (rpt_state[j])
                        RPT_IDLE: begin
                            rpt_cnt[j] <= '0;
                            if (rise[j]) begin
                                rpt_state[j] <= RPT_DELAY;
                                rpt_pulse[j] <= 1'b1;
                            end
                        end
                        RPT_DELAY: begin
                            if (rpt_cnt[j] == DELAY_LAST) begin
                                rpt_pulse[j] <= 1'b1;
                                rpt_cnt[j]   <= '0;
                                rpt_state[j] <= RPT_REPEAT;
                            end else begin
                                rpt_cnt[j] <= rpt_cnt[j] + RP_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rpt_cnt[j] == PERIOD_LAST) begin
                                rpt_pulse[j] <= 1'b1;
                                rpt_cnt[j]   <= '0;
                            end else begin
                                rpt_cnt[j] <= rpt_cnt[j] + RP_W'(1);
                            end
                        end
                        default: begin
                            rpt_state[j] <= RPT_IDLE;
                            rpt_cnt[j]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    assign BTN_LEVEL  = stable[3:0];
    assign SW_LEVEL   = stable[6:4];
    assign BTN_PRESS  = press_q;
    assign SW_CHANGE  = change_q;
    assign BTN_REPEAT = rpt_pulse;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=5. After a raw change first sampled at
// edge 0, register updates from edge k are observed after tick k+1.
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw;
    logic [2:0] sw_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [1:0] btn_repeat;
    logic [2:0] sw_level;
    logic [2:0] sw_change;

    int n_checks = 0;
    int n_fail   = 0;

    input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(5)
    ) dut (
        .CLK_40M   (clk),
        .RESET     (rst),
        .BTN_RAW   (btn_raw),
        .SW_RAW    (sw_raw),
        .BTN_LEVEL (btn_level),
        .BTN_PRESS (btn_press),
        .BTN_REPEAT(btn_repeat),
        .SW_LEVEL  (sw_level),
        .SW_CHANGE (sw_change)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        idle(2);

        // Reset state
        check("reset_btn_level", 32'(btn_level), 32'h0);
        check("reset_btn_press", 32'(btn_press), 32'h0);
        check("reset_btn_repeat", 32'(btn_repeat), 32'h0);
        check("reset_sw_level", 32'(sw_level), 32'h0);
        check("reset_sw_change", 32'(sw_change), 32'h0);
        rst = 1'b0;
        idle(3);

        // Clean press on A (bit 2): level/press at edge 5, no repeat activity
        btn_raw = 4'b0100;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("a_press t=%0d", t), 32'(btn_press), (t == 6) ? 32'h4 : 32'h0);
            check($sformatf("a_level t=%0d", t), 32'(btn_level), (t >= 6) ? 32'h4 : 32'h0);
            check($sformatf("a_repeat t=%0d", t), 32'(btn_repeat), 32'h0);
        end
        btn_raw = 4'b0000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            check($sformatf("a_rel_level t=%0d", t), 32'(btn_level), (t <= 5) ? 32'h4 : 32'h0);
            check($sformatf("a_rel_press t=%0d", t), 32'(btn_press), 32'h0);
        end
        idle(4);

        // Bounce on LEFT: 3 high, 1 low, 3 high, low -- never accepted
        for (int t = 1; t <= 14; t++) begin
            btn_raw[0] = ((t >= 1 && t <= 3) || (t >= 5 && t <= 7)) ? 1'b1 : 1'b0;
            tick();
            check($sformatf("bounce_level t=%0d", t), 32'(btn_level), 32'h0);
            check($sformatf("bounce_press t=%0d", t), 32'(btn_press), 32'h0);
            check($sformatf("bounce_repeat t=%0d", t), 32'(btn_repeat), 32'h0);
        end
        idle(4);

        // Auto-repeat on LEFT: press edge 5, repeats 15,20,...,45, falls at 46
        btn_raw = 4'b0001;
        for (int t = 1; t <= 55; t++) begin
            if (t == 42) btn_raw = 4'b0000;
            tick();
            check($sformatf("rpt_repeat t=%0d", t), 32'(btn_repeat),
                  ((t - 1) == 5 || ((t - 1) >= 15 && (t - 1) <= 45 && ((t - 1) % 5) == 0)) ? 32'h1 : 32'h0);
            check($sformatf("rpt_press t=%0d", t), 32'(btn_press), ((t - 1) == 5) ? 32'h1 : 32'h0);
            check($sformatf("rpt_level t=%0d", t), 32'(btn_level), (t >= 6 && t <= 46) ? 32'h1 : 32'h0);
        end
        idle(4);

        // Release RIGHT mid-delay: level falls at edge 12, no repeat at 15
        btn_raw = 4'b0010;
        for (int t = 1; t <= 20; t++) begin
            if (t == 8) btn_raw = 4'b0000;
            tick();
            check($sformatf("rel_repeat t=%0d", t), 32'(btn_repeat), ((t - 1) == 5) ? 32'h2 : 32'h0);
            check($sformatf("rel_level t=%0d", t), 32'(btn_level), (t >= 6 && t <= 12) ? 32'h2 : 32'h0);
        end
        // Re-press: fresh press/repeat after full debounce, first repeat +10
        btn_raw = 4'b0010;
        for (int t = 1; t <= 18; t++) begin
            tick();
            check($sformatf("repress_press t=%0d", t), 32'(btn_press), ((t - 1) == 5) ? 32'h2 : 32'h0);
            check($sformatf("repress_repeat t=%0d", t), 32'(btn_repeat),
                  ((t - 1) == 5 || (t - 1) == 15) ? 32'h2 : 32'h0);
        end
        btn_raw = 4'b0000;
        idle(10);

        // Switch PAUSE both edges: changes at edges 5 and 25
        sw_raw = 3'b010;
        for (int t = 1; t <= 30; t++) begin
            if (t == 21) sw_raw = 3'b000;
            tick();
            check($sformatf("sw_change t=%0d", t), 32'(sw_change), (t == 6 || t == 26) ? 32'h2 : 32'h0);
            check($sformatf("sw_level t=%0d", t), 32'(sw_level), (t >= 6 && t <= 25) ? 32'h2 : 32'h0);
        end
        idle(4);

        // Reset at edge 17 while LEFT is in REPEAT; re-press at edge 23
        btn_raw = 4'b0001;
        for (int t = 1; t <= 35; t++) begin
            if (t == 18) rst = 1'b1;
            tick();
            if (t == 18) begin
                rst = 1'b0;
                check("rst_mid_btn_level", 32'(btn_level), 32'h0);
                check("rst_mid_btn_press", 32'(btn_press), 32'h0);
                check("rst_mid_btn_repeat", 32'(btn_repeat), 32'h0);
                check("rst_mid_sw_level", 32'(sw_level), 32'h0);
                check("rst_mid_sw_change", 32'(sw_change), 32'h0);
            end
            check($sformatf("rstop_repeat t=%0d", t), 32'(btn_repeat),
                  ((t - 1) == 5 || (t - 1) == 15 || (t - 1) == 23 || (t - 1) == 33) ? 32'h1 : 32'h0);
            check($sformatf("rstop_press t=%0d", t), 32'(btn_press),
                  ((t - 1) == 5 || (t - 1) == 23) ? 32'h1 : 32'h0);
            check($sformatf("rstop_level t=%0d", t), 32'(btn_level),
                  ((t >= 6 && t <= 17) || t >= 24) ? 32'h1 : 32'h0);
        end
        btn_raw = 4'b0000;
        idle(10);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
